// File: rtl/control_unit_if.sv
// Control bundle between the microsequencer and the 12-bit accumulator datapath.
// master = sequencer (drives strobes, reads opcode/Zflag); slave = datapath side.
interface control_unit_if #(
  parameter int opcode_width = 4
);
  logic [opcode_width-1:0] opcode;
  logic                    Zflag;
  logic [2:0]              ALU_Operation;
  logic [2:0]              bus_sel;
  logic                    MAR_ld;
  logic                    IR_ld;
  logic                    AC_ld;
  logic                    PC_ld;
  logic                    PC_inc;
  logic                    mem_rd;
  logic                    mem_wr;
  logic                    halted;

  modport master (
    input  opcode, Zflag,
    output ALU_Operation, bus_sel, MAR_ld, IR_ld, AC_ld, PC_ld, PC_inc,
           mem_rd, mem_wr, halted
  );

  modport slave (
    output opcode, Zflag,
    input  ALU_Operation, bus_sel, MAR_ld, IR_ld, AC_ld, PC_ld, PC_inc,
           mem_rd, mem_wr, halted
  );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute microsequencer; outputs decoded combinationally from state+opcode (0-cycle).
// No backpressure: one instruction at a time, 4-7 cycles each; HALT holds until reset.
module control_unit #(
  parameter int opcode_width = 4
) (
  input  logic             clk,
  input  logic             reset,
  control_unit_if.master   cu
);

  typedef enum logic [3:0] {
    S_RST, FETCH1, FETCH2, FETCH3, DECODE, MEM1, MEM2, EXEC, STORE, JUMP, HALT
  } state_t;

  localparam logic [opcode_width-1:0] op_ldac = opcode_width'(1);
  localparam logic [opcode_width-1:0] op_stac = opcode_width'(2);
  localparam logic [opcode_width-1:0] op_add  = opcode_width'(3);
  localparam logic [opcode_width-1:0] op_sub  = opcode_width'(4);
  localparam logic [opcode_width-1:0] op_mul  = opcode_width'(5);
  localparam logic [opcode_width-1:0] op_inac = opcode_width'(6);
  localparam logic [opcode_width-1:0] op_clac = opcode_width'(7);
  localparam logic [opcode_width-1:0] op_jmp  = opcode_width'(8);
  localparam logic [opcode_width-1:0] op_jmpz = opcode_width'(9);
  localparam logic [opcode_width-1:0] op_halt = opcode_width'(15);

  localparam logic [2:0] alu_idle  = 3'b000;
  localparam logic [2:0] alu_pass  = 3'b001;
  localparam logic [2:0] alu_add   = 3'b010;
  localparam logic [2:0] alu_sub   = 3'b011;
  localparam logic [2:0] alu_mul   = 3'b100;
  localparam logic [2:0] alu_plus1 = 3'b101;
  localparam logic [2:0] alu_zero  = 3'b110;

  localparam logic [2:0] bus_none = 3'd0;
  localparam logic [2:0] bus_pc   = 3'd1;
  localparam logic [2:0] bus_dr   = 3'd2;
  localparam logic [2:0] bus_ac   = 3'd3;
  localparam logic [2:0] bus_ir   = 3'd4;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_RST;
    else        state <= state_next;
  end

  always_comb begin
    state_next       = state;
    cu.ALU_Operation = alu_idle;
    cu.bus_sel       = bus_none;
    cu.MAR_ld        = 1'b0;
    cu.IR_ld         = 1'b0;
    cu.AC_ld         = 1'b0;
    cu.PC_ld         = 1'b0;
    cu.PC_inc        = 1'b0;
    cu.mem_rd        = 1'b0;
    cu.mem_wr        = 1'b0;
    cu.halted        = 1'b0;

    case (state)
      S_RST:  state_next = FETCH1;
      FETCH1: begin
        cu.bus_sel = bus_pc;
        cu.MAR_ld  = 1'b1;
        state_next = FETCH2;
      end
      FETCH2: begin
        cu.mem_rd  = 1'b1;
        cu.PC_inc  = 1'b1;
        state_next = FETCH3;
      end
      FETCH3: begin
        cu.bus_sel = bus_dr;
        cu.IR_ld   = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        if (cu.opcode == op_ldac || cu.opcode == op_add || cu.opcode == op_sub ||
            cu.opcode == op_mul  || cu.opcode == op_stac)
          state_next = MEM1;
        else if (cu.opcode == op_inac || cu.opcode == op_clac)
          state_next = EXEC;
        else if (cu.opcode == op_jmp || (cu.opcode == op_jmpz && cu.Zflag))
          state_next = JUMP;
        else if (cu.opcode == op_halt)
          state_next = HALT;
        else
          state_next = FETCH1;
      end
      MEM1: begin
        cu.bus_sel = bus_ir;
        cu.MAR_ld  = 1'b1;
        state_next = (cu.opcode == op_stac) ? STORE : MEM2;
      end
      MEM2: begin
        cu.mem_rd  = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        cu.AC_ld   = 1'b1;
        state_next = FETCH1;
        // DR-sourced ops put memory data on the bus; INAC/CLAC leave it idle
        if      (cu.opcode == op_ldac) begin cu.ALU_Operation = alu_pass;  cu.bus_sel = bus_dr; end
        else if (cu.opcode == op_add)  begin cu.ALU_Operation = alu_add;   cu.bus_sel = bus_dr; end
        else if (cu.opcode == op_sub)  begin cu.ALU_Operation = alu_sub;   cu.bus_sel = bus_dr; end
        else if (cu.opcode == op_mul)  begin cu.ALU_Operation = alu_mul;   cu.bus_sel = bus_dr; end
        else if (cu.opcode == op_inac) cu.ALU_Operation = alu_plus1;
        else if (cu.opcode == op_clac) cu.ALU_Operation = alu_zero;
      end
      STORE: begin
        cu.bus_sel = bus_ac;
        cu.mem_wr  = 1'b1;
        state_next = FETCH1;
      end
      JUMP: begin
        cu.bus_sel = bus_ir;
        cu.PC_ld   = 1'b1;
        state_next = FETCH1;
      end
      HALT:    cu.halted = 1'b1;
      default: state_next = S_RST;
    endcase

    if (!reset) begin
      cu.ALU_Operation = alu_idle;
      cu.bus_sel       = bus_none;
      cu.MAR_ld        = 1'b0;
      cu.IR_ld         = 1'b0;
      cu.AC_ld         = 1'b0;
      cu.PC_ld         = 1'b0;
      cu.PC_inc        = 1'b0;
      cu.mem_rd        = 1'b0;
      cu.mem_wr        = 1'b0;
      cu.halted        = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench: per-instruction cycle-by-cycle strobe sequences built from the instruction set
// description, compared against the sequencer every cycle, including reset pulses and HALT.
module tb_control_unit;

  typedef struct packed {
    logic [2:0] alu;
    logic [2:0] bus;
    logic       mar, ir, ac, pcld, pcinc, rd, wr, halted;
  } ov_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  ov_t  exp_q[$];

  control_unit_if #(.opcode_width(4)) bus_if ();

  control_unit #(.opcode_width(4)) dut (
    .clk   (clk),
    .reset (reset),
    .cu    (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ov_t observe();
    ov_t o;
    o.alu    = bus_if.ALU_Operation;
    o.bus    = bus_if.bus_sel;
    o.mar    = bus_if.MAR_ld;
    o.ir     = bus_if.IR_ld;
    o.ac     = bus_if.AC_ld;
    o.pcld   = bus_if.PC_ld;
    o.pcinc  = bus_if.PC_inc;
    o.rd     = bus_if.mem_rd;
    o.wr     = bus_if.mem_wr;
    o.halted = bus_if.halted;
    return o;
  endfunction

  function automatic ov_t mk(input logic [2:0] alu, input logic [2:0] bus, input logic [7:0] fl);
    ov_t o;
    o.alu = alu;
    o.bus = bus;
    {o.mar, o.ir, o.ac, o.pcld, o.pcinc, o.rd, o.wr, o.halted} = fl;
    return o;
  endfunction

  // flag order: mar ir ac pcld pcinc rd wr halted
  function automatic void build(input logic [3:0] op, input logic z, input int halt_cycles);
    logic [2:0] alu_code;
    exp_q.delete();
    exp_q.push_back(mk(3'd0, 3'd1, 8'b1000_0000));
    exp_q.push_back(mk(3'd0, 3'd0, 8'b0000_1100));
    exp_q.push_back(mk(3'd0, 3'd2, 8'b0100_0000));
    exp_q.push_back(mk(3'd0, 3'd0, 8'b0000_0000));
    case (op)
      4'd1, 4'd3, 4'd4, 4'd5: begin
        alu_code = (op == 4'd1) ? 3'b001 : (op == 4'd3) ? 3'b010 : (op == 4'd4) ? 3'b011 : 3'b100;
        exp_q.push_back(mk(3'd0, 3'd4, 8'b1000_0000));
        exp_q.push_back(mk(3'd0, 3'd0, 8'b0000_0100));
        exp_q.push_back(mk(alu_code, 3'd2, 8'b0010_0000));
      end
      4'd2: begin
        exp_q.push_back(mk(3'd0, 3'd4, 8'b1000_0000));
        exp_q.push_back(mk(3'd0, 3'd3, 8'b0000_0010));
      end
      4'd6: exp_q.push_back(mk(3'b101, 3'd0, 8'b0010_0000));
      4'd7: exp_q.push_back(mk(3'b110, 3'd0, 8'b0010_0000));
      4'd8: exp_q.push_back(mk(3'd0, 3'd4, 8'b0001_0000));
      4'd9: if (z) exp_q.push_back(mk(3'd0, 3'd4, 8'b0001_0000));
      4'd15: for (int i = 0; i < halt_cycles; i++) exp_q.push_back(mk(3'd0, 3'd0, 8'b0000_0001));
      default: ;
    endcase
  endfunction

  // Runs up to max_cycles of one instruction; opcode is random before FETCH3, Zflag random except DECODE.
  task automatic run_instr(input logic [3:0] op, input logic z, input int max_cycles);
    ov_t o;
    build(op, z, 20);
    for (int i = 0; i < exp_q.size() && i < max_cycles; i++) begin
      @(negedge clk);
      bus_if.opcode = (i < 2) ? 4'($urandom_range(0, 15)) : op;
      bus_if.Zflag  = (i == 3) ? z : 1'($urandom_range(0, 1));
      #1;
      o = observe();
      check($sformatf("op%0h_z%0d_c%0d", op, z, i), 32'(o), 32'(exp_q[i]));
    end
  endtask

  task automatic reset_pulse(input int n);
    ov_t o;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b0;
      bus_if.opcode = 4'($urandom_range(0, 15));
      bus_if.Zflag  = 1'($urandom_range(0, 1));
      #1;
      o = observe();
      check($sformatf("rst_hold_%0d", i), 32'(o), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    o = observe();
    check("rst_release_s_rst", 32'(o), 32'd0);
  endtask

  initial begin
    logic [3:0] op;
    bus_if.opcode = '0;
    bus_if.Zflag  = 1'b0;
    reset_pulse(3);

    run_instr(4'd3, 1'b0, 100);
    run_instr(4'd6, 1'b1, 100);
    run_instr(4'd7, 1'b0, 100);
    run_instr(4'd9, 1'b0, 100);
    run_instr(4'd9, 1'b1, 100);
    run_instr(4'd2, 1'b1, 100);
    run_instr(4'd10, 1'b1, 100);
    run_instr(4'd8, 1'b0, 100);
    run_instr(4'd1, 1'b0, 100);
    run_instr(4'd4, 1'b1, 100);
    run_instr(4'd5, 1'b0, 100);
    run_instr(4'd0, 1'b1, 100);

    // ADD interrupted in its EXEC cycle (cycle index 6)
    run_instr(4'd3, 1'b0, 6);
    reset_pulse(3);
    run_instr(4'd3, 1'b1, 100);

    run_instr(4'd15, 1'b0, 100);
    reset_pulse(1);

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, 1'($urandom_range(0, 1)), 100);
    end

    run_instr(4'd15, 1'b1, 100);
    reset_pulse(2);
    run_instr(4'd6, 1'b0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
